decapsulation: RTL and testbench

//  Ethernet RX frame parser on the GMII receive path; the receive-side counterpart of the TX encapsulation block.

---
 rtl/eth_pkg.sv | 44 ++++
 rtl/crc32_comb.sv | 36 +++
 rtl/decapsulation.sv | 275 +++++++++++++++++++++++++++
 tb/tb_decapsulation.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet RX framing constants, parser states and drop causes
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          LEN_ADDR      = 6;
  localparam int          LEN_LEN       = 2;
  localparam int          LEN_CRC       = 4;
  localparam int          MAX_PAYLOAD   = 1500;
  localparam logic [15:0] TYPE_MIN      = 16'h0600;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DEST_MAC = 3'd2,
    SRC_MAC  = 3'd3,
    LEN      = 3'd4,
    PAYLOAD  = 3'd5,
    CHECK    = 3'd6,
    DISCARD  = 3'd7
  } rx_state_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_CRC       = 3'd1,
    ERR_RUNT      = 3'd2,
    ERR_OVERSIZE  = 3'd3,
    ERR_RX_ER     = 3'd4,
    ERR_FIFO_FULL = 3'd5,
    ERR_ADDR      = 3'd6
  } rx_err_t;

  // One byte of the reflected Ethernet CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_comb.sv
// rtl/crc32_comb.sv - Running Ethernet CRC-32 with combinational byte update
module crc32_comb
  import eth_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        crc_reset_i,
  input  logic        update_crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs;

  // Next CRC: restart on reset request, otherwise fold in one byte when asked.
  always_comb begin
    crc_d = crc_q;
    if (crc_reset_i) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (update_crc_i) begin
      crc_d = crc32_step(crc_q, data_i);
    end
  end

  // CRC accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 32'hFFFF_FFFF;
    else         crc_q <= crc_d;
  end

  // Result is byte-ordered as it appears on the wire: first FCS byte in [31:24].
  assign fcs   = ~crc_q;
  assign crc_o = {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};

endmodule

// File: rtl/decapsulation.sv
// rtl/decapsulation.sv - GMII RX frame parser: address filter, FCS check, payload to RX FIFO
module decapsulation
  import eth_pkg::*;
#(
  parameter logic [47:0] own_mac_addr = 48'h023528fbdd66,
  parameter bit          PROMISC      = 1'b0,
  parameter int          MIN_FRAME    = 64,
  parameter int          MAX_FRAME    = 1518
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        bf_out_buffer_full,
  output logic [7:0]  ff_in_data,
  output logic        ff_in_w_en,
  output logic        bf_in_pct_rxed,
  output logic        bf_in_pct_drop,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_len,
  output logic [2:0]  rx_err_code
);

  localparam logic [15:0] FRAME_SAT = 16'(MAX_FRAME + 1);
  localparam logic [15:0] FRAME_MAX = 16'(MAX_FRAME);
  localparam logic [15:0] FRAME_MIN = 16'(MIN_FRAME);
  localparam logic [15:0] PAY_MAX   = 16'(MAX_PAYLOAD);
  localparam logic [2:0]  LINE_FULL = 3'(LEN_CRC);
  localparam logic [2:0]  ADDR_LAST = 3'(LEN_ADDR - 1);
  localparam logic [2:0]  LEN_LAST  = 3'(LEN_LEN - 1);

  rx_state_t        state_q, state_d;
  logic             prev_dv_q;
  logic [3:0][7:0]  line_q, line_d;
  logic [2:0]       fill_q, fill_d;
  logic [2:0]       fld_q, fld_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      pay_cnt_q, pay_cnt_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;
  logic [39:0]      dest_q, dest_d;
  logic [47:0]      src_q, src_d;
  logic [15:0]      len_q, len_d;
  logic             er_seen_q, er_seen_d;
  logic             full_seen_q, full_seen_d;
  logic             len_bad_q, len_bad_d;
  rx_err_t          err_q, err_d;
  logic [7:0]       data_q, data_d;
  logic             w_en_q, w_en_d;
  logic             rxed_q, rxed_d;
  logic             drop_q, drop_d;
  logic [47:0]      src_mac_q, src_mac_d;
  logic [15:0]      rx_len_q, rx_len_d;
  logic [2:0]       err_code_q, err_code_d;

  logic             in_frame, out_valid, sfd_hit, addr_ok, want_write, er_now;
  logic [7:0]       out_byte;
  logic [47:0]      dest_full;
  logic [15:0]      len_full;
  logic [31:0]      crc_res;
  rx_err_t          chk_err;

  // The parser only ever sees the byte leaving the 4-byte line, so FCS stays behind.
  assign in_frame   = (state_q inside {DEST_MAC, SRC_MAC, LEN, PAYLOAD});
  assign out_valid  = in_frame && gmii_rx_dv && (fill_q == LINE_FULL);
  assign out_byte   = line_q[3];
  assign sfd_hit    = (state_q == PREAMBLE) && gmii_rx_dv && (gmii_rxd == SFD_BYTE);
  assign dest_full  = {dest_q, out_byte};
  assign len_full   = {len_q[7:0], out_byte};
  assign addr_ok    = PROMISC || (dest_full == own_mac_addr) || (dest_full == BROADCAST_MAC);
  assign want_write = (len_q >= TYPE_MIN) || (pay_cnt_q < len_q);
  assign er_now     = er_seen_q || (gmii_rx_dv && gmii_rx_er);

  crc32_comb u_crc (
    .clk_i        (eth_rx_clk),
    .rst_ni       (rst),
    .crc_reset_i  (sfd_hit),
    .update_crc_i (out_valid),
    .data_i       (out_byte),
    .crc_o        (crc_res)
  );

  // State register.
  always_ff @(posedge eth_rx_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: frame boundaries come from rx_dv, field boundaries from the field counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gmii_rx_dv && !prev_dv_q && (gmii_rxd == PREAMBLE_BYTE)) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!gmii_rx_dv)                    state_d = IDLE;
        else if (gmii_rxd == SFD_BYTE)      state_d = DEST_MAC;
        else if (gmii_rxd != PREAMBLE_BYTE) state_d = DISCARD;
      end
      DEST_MAC: begin
        if (!gmii_rx_dv) state_d = CHECK;
        else if (out_valid && (fld_q == ADDR_LAST)) state_d = addr_ok ? SRC_MAC : DISCARD;
      end
      SRC_MAC: begin
        if (!gmii_rx_dv) state_d = CHECK;
        else if (out_valid && (fld_q == ADDR_LAST)) state_d = LEN;
      end
      LEN: begin
        if (!gmii_rx_dv) state_d = CHECK;
        else if (out_valid && (fld_q == LEN_LAST)) state_d = PAYLOAD;
      end
      PAYLOAD:  if (!gmii_rx_dv) state_d = CHECK;
      CHECK:    state_d = IDLE;
      DISCARD:  if (!gmii_rx_dv) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // End-of-frame verdict in fixed priority order.
  always_comb begin
    chk_err = ERR_NONE;
    if (er_seen_q)                                 chk_err = ERR_RX_ER;
    else if (full_seen_q)                          chk_err = ERR_FIFO_FULL;
    else if (len_bad_q || (frame_cnt_q > FRAME_MAX)) chk_err = ERR_OVERSIZE;
    else if (frame_cnt_q < FRAME_MIN)              chk_err = ERR_RUNT;
    else if (line_q != crc_res)                    chk_err = ERR_CRC;
  end

  // Datapath and output next-values driven by the current state.
  always_comb begin
    line_d      = line_q;
    fill_d      = fill_q;
    frame_cnt_d = frame_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    dest_d      = dest_q;
    src_d       = src_q;
    len_d       = len_q;
    er_seen_d   = er_seen_q;
    full_seen_d = full_seen_q;
    len_bad_d   = len_bad_q;
    err_d       = err_q;
    data_d      = data_q;
    w_en_d      = 1'b0;
    rxed_d      = 1'b0;
    drop_d      = 1'b0;
    src_mac_d   = src_mac_q;
    rx_len_d    = rx_len_q;
    err_code_d  = err_code_q;
    fld_d       = (state_d != state_q) ? 3'd0 : (fld_q + {2'b00, out_valid});

    if (sfd_hit) begin
      fill_d      = 3'd0;
      frame_cnt_d = 16'd0;
      pay_cnt_d   = 16'd0;
      wr_cnt_d    = 16'd0;
      er_seen_d   = 1'b0;
      full_seen_d = 1'b0;
      len_bad_d   = 1'b0;
      err_d       = ERR_NONE;
    end

    if (in_frame && gmii_rx_dv) begin
      line_d = {line_q[2:0], gmii_rxd};
      if (fill_q != LINE_FULL)      fill_d      = fill_q + 3'd1;
      if (frame_cnt_q != FRAME_SAT) frame_cnt_d = frame_cnt_q + 16'd1;
      if (gmii_rx_er)               er_seen_d   = 1'b1;
    end

    if (out_valid) begin
      case (state_q)
        DEST_MAC: begin
          dest_d = dest_full[39:0];
          if ((fld_q == ADDR_LAST) && !addr_ok) err_d = ERR_ADDR;
        end
        SRC_MAC: src_d = {src_q[39:0], out_byte};
        LEN: begin
          len_d = len_full;
          if ((fld_q == LEN_LAST) && (len_full > PAY_MAX) && (len_full < TYPE_MIN)) len_bad_d = 1'b1;
        end
        PAYLOAD: begin
          if (pay_cnt_q != FRAME_SAT) pay_cnt_d = pay_cnt_q + 16'd1;
          if (want_write && !len_bad_q && !er_now && !full_seen_q) begin
            if (bf_out_buffer_full) begin
              full_seen_d = 1'b1;
            end else begin
              w_en_d   = 1'b1;
              data_d   = out_byte;
              wr_cnt_d = wr_cnt_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (state_q == CHECK) begin
      wr_cnt_d = 16'd0;
      if (chk_err != ERR_NONE) begin
        drop_d     = 1'b1;
        err_code_d = chk_err;
      end else begin
        rxed_d    = 1'b1;
        src_mac_d = src_q;
        rx_len_d  = wr_cnt_q;
      end
    end

    // A discarded frame only needs a drop pulse if something already reached the FIFO.
    if ((state_q == DISCARD) && !gmii_rx_dv) begin
      wr_cnt_d = 16'd0;
      if (wr_cnt_q != 16'd0) begin
        drop_d     = 1'b1;
        err_code_d = err_q;
      end
    end
  end

  // Datapath and output registers; prev_dv resets high so a frame tail is ignored.
  always_ff @(posedge eth_rx_clk or negedge rst) begin
    if (!rst) begin
      prev_dv_q   <= 1'b1;
      line_q      <= '0;
      fill_q      <= 3'd0;
      fld_q       <= 3'd0;
      frame_cnt_q <= 16'd0;
      pay_cnt_q   <= 16'd0;
      wr_cnt_q    <= 16'd0;
      dest_q      <= 40'd0;
      src_q       <= 48'd0;
      len_q       <= 16'd0;
      er_seen_q   <= 1'b0;
      full_seen_q <= 1'b0;
      len_bad_q   <= 1'b0;
      err_q       <= ERR_NONE;
      data_q      <= 8'd0;
      w_en_q      <= 1'b0;
      rxed_q      <= 1'b0;
      drop_q      <= 1'b0;
      src_mac_q   <= 48'd0;
      rx_len_q    <= 16'd0;
      err_code_q  <= 3'd0;
    end else begin
      prev_dv_q   <= gmii_rx_dv;
      line_q      <= line_d;
      fill_q      <= fill_d;
      fld_q       <= fld_d;
      frame_cnt_q <= frame_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      dest_q      <= dest_d;
      src_q       <= src_d;
      len_q       <= len_d;
      er_seen_q   <= er_seen_d;
      full_seen_q <= full_seen_d;
      len_bad_q   <= len_bad_d;
      err_q       <= err_d;
      data_q      <= data_d;
      w_en_q      <= w_en_d;
      rxed_q      <= rxed_d;
      drop_q      <= drop_d;
      src_mac_q   <= src_mac_d;
      rx_len_q    <= rx_len_d;
      err_code_q  <= err_code_d;
    end
  end

  assign ff_in_data     = data_q;
  assign ff_in_w_en     = w_en_q;
  assign bf_in_pct_rxed = rxed_q;
  assign bf_in_pct_drop = drop_q;
  assign rx_src_mac     = src_mac_q;
  assign rx_len         = rx_len_q;
  assign rx_err_code    = err_code_q;

endmodule

// File: tb/tb_decapsulation.sv
// tb/tb_decapsulation.sv - Directed self-checking bench for the RX decapsulation block
module tb_decapsulation;

  typedef logic [7:0] byte_q_t [$];

  localparam logic [47:0] OWN  = 48'h023528fbdd66;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC1 = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] SRC2 = 48'h112233445566;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0, er = 1'b0, full = 1'b0;

  logic [7:0]  ff_data, ff_data_p;
  logic        w_en, w_en_p, rxed, rxed_p, drop, drop_p;
  logic [47:0] src_mac, src_mac_p;
  logic [15:0] len_o, len_o_p;
  logic [2:0]  err_o, err_o_p;

  int n_checks = 0, n_pass = 0;
  int wr_cnt = 0, data_bad = 0, rxed_cnt = 0, drop_cnt = 0, both_cnt = 0;
  int rxed_p_cnt = 0, drop_p_cnt = 0;

  always #4 clk = ~clk;

  decapsulation dut (
    .eth_rx_clk(clk), .rst(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .bf_out_buffer_full(full), .ff_in_data(ff_data), .ff_in_w_en(w_en),
    .bf_in_pct_rxed(rxed), .bf_in_pct_drop(drop), .rx_src_mac(src_mac),
    .rx_len(len_o), .rx_err_code(err_o)
  );

  decapsulation #(.PROMISC(1'b1)) dut_p (
    .eth_rx_clk(clk), .rst(rst_n), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .bf_out_buffer_full(full), .ff_in_data(ff_data_p), .ff_in_w_en(w_en_p),
    .bf_in_pct_rxed(rxed_p), .bf_in_pct_drop(drop_p), .rx_src_mac(src_mac_p),
    .rx_len(len_o_p), .rx_err_code(err_o_p)
  );

  // Monitor on the falling edge: count writes/pulses, payload bytes must run 00,01,02...
  always @(negedge clk) begin
    if (w_en) begin
      if (ff_data !== 8'(wr_cnt)) data_bad++;
      wr_cnt++;
    end
    if (rxed) rxed_cnt++;
    if (drop) drop_cnt++;
    if (rxed && drop) both_cnt++;
    if (rxed_p) rxed_p_cnt++;
    if (drop_p) drop_p_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    wr_cnt = 0; data_bad = 0; rxed_cnt = 0; drop_cnt = 0; rxed_p_cnt = 0; drop_p_cnt = 0;
  endtask

  function automatic logic [31:0] crc_ref(input byte_q_t q);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic byte_q_t build(input logic [47:0] dst, input logic [47:0] src,
                                    input logic [15:0] len, input int n, input bit bad);
    byte_q_t     q;
    logic [31:0] c;
    for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(src[47-8*i -: 8]);
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    c = crc_ref(q);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[23:16]);
    q.push_back(c[31:24]);
    if (bad) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
    return q;
  endfunction

  task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic f);
    @(posedge clk);
    #1;
    rxd = d; dv = v; er = e; full = f;
  endtask

  task automatic send(input byte_q_t fr, input int er_i, input int full_i, input int rst_i);
    repeat (7) drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < fr.size(); i++) begin
      drive(fr[i], 1'b1, i == er_i, i == full_i);
      if (rst_i >= 0 && i == rst_i) rst_n = 1'b0;
      if (rst_i >= 0 && i == rst_i + 2) begin
        rst_n = 1'b1;
        clr();
      end
    end
    repeat (9) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    byte_q_t f;
    repeat (3) @(posedge clk);
    #1;
    check("reset_w_en", w_en, 0);
    check("reset_rxed", rxed, 0);
    check("reset_drop", drop, 0);
    check("reset_src_mac", src_mac, 0);
    check("reset_rx_len", len_o, 0);
    check("reset_err", err_o, 0);
    rst_n = 1'b1;
    repeat (2) drive(8'h00, 1'b0, 1'b0, 1'b0);

    // Good 64-byte frame to own address
    clr(); f = build(OWN, SRC1, 16'h002E, 46, 1'b0); send(f, -1, -1, -1);
    check("t1_writes", wr_cnt, 46);
    check("t1_data", data_bad, 0);
    check("t1_rxed", rxed_cnt, 1);
    check("t1_drop", drop_cnt, 0);
    check("t1_rx_len", len_o, 46);
    check("t1_src_mac", src_mac, SRC1);

    // Corrupted FCS
    clr(); f = build(OWN, SRC2, 16'h002E, 46, 1'b1); send(f, -1, -1, -1);
    check("t2_writes", wr_cnt, 46);
    check("t2_drop", drop_cnt, 1);
    check("t2_rxed", rxed_cnt, 0);
    check("t2_err", err_o, 1);
    check("t2_src_kept", src_mac, SRC1);

    // Short length with pad, broadcast destination
    clr(); f = build(BC, SRC2, 16'h0004, 46, 1'b0); send(f, -1, -1, -1);
    check("t3_writes", wr_cnt, 4);
    check("t3_data", data_bad, 0);
    check("t3_rxed", rxed_cnt, 1);
    check("t3_rx_len", len_o, 4);
    check("t3_src_mac", src_mac, SRC2);

    // Foreign destination: filtered normally, accepted in promiscuous mode
    clr(); f = build(OWN ^ 48'h1, SRC1, 16'h002E, 46, 1'b0); send(f, -1, -1, -1);
    check("t4_writes", wr_cnt, 0);
    check("t4_rxed", rxed_cnt, 0);
    check("t4_drop", drop_cnt, 0);
    check("t4_promisc_rxed", rxed_p_cnt, 1);
    check("t4_promisc_len", len_o_p, 46);

    // rx_er alongside payload byte 10: bytes 0..5 already left the line
    clr(); f = build(OWN, SRC1, 16'h002E, 46, 1'b0); send(f, 24, -1, -1);
    check("t5a_writes", wr_cnt, 6);
    check("t5a_drop", drop_cnt, 1);
    check("t5a_err", err_o, 4);

    // FIFO full alongside payload byte 20: bytes 0..15 written
    clr(); f = build(OWN, SRC1, 16'h002E, 46, 1'b0); send(f, -1, 34, -1);
    check("t5b_writes", wr_cnt, 16);
    check("t5b_drop", drop_cnt, 1);
    check("t5b_err", err_o, 5);

    // 40-byte runt with valid FCS
    clr(); f = build(OWN, SRC1, 16'h0016, 22, 1'b0); send(f, -1, -1, -1);
    check("t5c_writes", wr_cnt, 22);
    check("t5c_drop", drop_cnt, 1);
    check("t5c_err", err_o, 2);

    // Reset mid-payload with rx_dv still high, then a clean frame
    clr(); f = build(OWN, SRC2, 16'h002E, 46, 1'b0); send(f, -1, -1, 30);
    check("t6_writes", wr_cnt, 0);
    check("t6_rxed", rxed_cnt, 0);
    check("t6_drop", drop_cnt, 0);
    check("t6_rx_len", len_o, 0);
    clr(); f = build(OWN, SRC1, 16'h002E, 46, 1'b0); send(f, -1, -1, -1);
    check("t6_next_rxed", rxed_cnt, 1);
    check("t6_next_len", len_o, 46);

    check("pulses_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
